wb_arb2_rr: RTL and testbench

Two-requester round-robin Wishbone arbiter placed in front of a generated register bank (32-bit data, pipelined Wishbone with stall). Each requester (e.g. host bridge and on-chip configuration sequencer) issues single classic-pipelined transactions. The arbiter latches one request at a time, replays it to the shared slave, and returns the registered response to the owner. A watchdog converts missing slave acks into errors.

---
 rtl/wb_arb2_rr.sv | 178 +++++++++++++++++
 tb/tb_wb_arb2_rr.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2_rr.sv
// Two-requester round-robin Wishbone arbiter. A request is latched, replayed to the slave, and the response is returned registered.
// A missing slave response is converted into an error by the watchdog.
module wb_arb2_rr #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              m0_wb_cyc_i,
    input  logic              m0_wb_stb_i,
    input  logic              m0_wb_we_i,
    input  logic [ADDR_W-1:0] m0_wb_adr_i,
    input  logic [3:0]        m0_wb_sel_i,
    input  logic [31:0]       m0_wb_dat_i,
    output logic              m0_wb_ack_o,
    output logic              m0_wb_err_o,
    output logic              m0_wb_rty_o,
    output logic              m0_wb_stall_o,
    output logic [31:0]       m0_wb_dat_o,
    input  logic              m1_wb_cyc_i,
    input  logic              m1_wb_stb_i,
    input  logic              m1_wb_we_i,
    input  logic [ADDR_W-1:0] m1_wb_adr_i,
    input  logic [3:0]        m1_wb_sel_i,
    input  logic [31:0]       m1_wb_dat_i,
    output logic              m1_wb_ack_o,
    output logic              m1_wb_err_o,
    output logic              m1_wb_rty_o,
    output logic              m1_wb_stall_o,
    output logic [31:0]       m1_wb_dat_o,
    output logic              s_wb_cyc_o,
    output logic              s_wb_stb_o,
    output logic              s_wb_we_o,
    output logic [ADDR_W-1:0] s_wb_adr_o,
    output logic [3:0]        s_wb_sel_o,
    output logic [31:0]       s_wb_dat_o,
    input  logic              s_wb_ack_i,
    input  logic              s_wb_err_i,
    input  logic              s_wb_rty_i,
    input  logic              s_wb_stall_i,
    input  logic [31:0]       s_wb_dat_i
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [3:0]          sel_q, sel_d;
    logic [31:0]         wdat_q, wdat_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                rty_q, rty_d;
    logic [31:0]         rdat_q, rdat_d;

    logic [1:0] cand;
    logic       grant_sel;
    logic       owner_cyc;
    logic       slv_resp;

    assign cand      = {m1_wb_cyc_i & m1_wb_stb_i, m0_wb_cyc_i & m0_wb_stb_i};
    // Under contention the requester that did not win last time is chosen.
    assign grant_sel = (cand == 2'b11) ? ~last_grant_q : cand[1];
    assign owner_cyc = owner_q ? m1_wb_cyc_i : m0_wb_cyc_i;
    assign slv_resp  = s_wb_ack_i | s_wb_err_i | s_wb_rty_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            sel_q        <= '0;
            wdat_q       <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            rty_q        <= 1'b0;
            rdat_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            sel_q        <= sel_d;
            wdat_q       <= wdat_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rty_q        <= rty_d;
            rdat_q       <= rdat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        adr_d        = adr_q;
        sel_d        = sel_q;
        wdat_d       = wdat_q;
        ack_d        = ack_q;
        err_d        = err_q;
        rty_d        = rty_q;
        rdat_d       = rdat_q;
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d      = REQ;
                    owner_d      = grant_sel;
                    last_grant_d = grant_sel;
                    we_d         = grant_sel ? m1_wb_we_i  : m0_wb_we_i;
                    adr_d        = grant_sel ? m1_wb_adr_i : m0_wb_adr_i;
                    sel_d        = grant_sel ? m1_wb_sel_i : m0_wb_sel_i;
                    wdat_d       = grant_sel ? m1_wb_dat_i : m0_wb_dat_i;
                end
            end
            REQ: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                end else if (!s_wb_stall_i) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                // Abort beats a same-cycle response; a response beats expiry.
                if (!owner_cyc) begin
                    state_d = IDLE;
                end else if (slv_resp) begin
                    state_d = RESP;
                    ack_d   = s_wb_ack_i;
                    err_d   = ~s_wb_ack_i & s_wb_err_i;
                    rty_d   = ~s_wb_ack_i & ~s_wb_err_i & s_wb_rty_i;
                    rdat_d  = (s_wb_ack_i && !we_q) ? s_wb_dat_i : 32'h0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = RESP;
                    ack_d   = 1'b0;
                    err_d   = 1'b1;
                    rty_d   = 1'b0;
                    rdat_d  = 32'h0;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_wb_cyc_o    = (state_q == REQ) || (state_q == WAIT);
        s_wb_stb_o    = (state_q == REQ);
        s_wb_we_o     = (state_q == REQ) ? we_q   : 1'b0;
        s_wb_adr_o    = (state_q == REQ) ? adr_q  : '0;
        s_wb_sel_o    = (state_q == REQ) ? sel_q  : 4'h0;
        s_wb_dat_o    = (state_q == REQ) ? wdat_q : 32'h0;
        // Stall is held high while reset is asserted, even with a request pending.
        m0_wb_stall_o = ~(rst_n_i && (state_q == IDLE) && (|cand) && !grant_sel);
        m1_wb_stall_o = ~(rst_n_i && (state_q == IDLE) && (|cand) && grant_sel);
        m0_wb_ack_o   = (state_q == RESP) && !owner_q && ack_q;
        m0_wb_err_o   = (state_q == RESP) && !owner_q && err_q;
        m0_wb_rty_o   = (state_q == RESP) && !owner_q && rty_q;
        m0_wb_dat_o   = ((state_q == RESP) && !owner_q) ? rdat_q : 32'h0;
        m1_wb_ack_o   = (state_q == RESP) && owner_q && ack_q;
        m1_wb_err_o   = (state_q == RESP) && owner_q && err_q;
        m1_wb_rty_o   = (state_q == RESP) && owner_q && rty_q;
        m1_wb_dat_o   = ((state_q == RESP) && owner_q) ? rdat_q : 32'h0;
    end

endmodule

// File: tb/tb_wb_arb2_rr.sv
// Directed bench for wb_arb2_rr: the slave is driven by hand from each scenario task.
module tb_wb_arb2_rr;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i;
    logic [3:0]  m0_wb_adr_i, m0_wb_sel_i;
    logic [31:0] m0_wb_dat_i;
    logic        m0_wb_ack_o, m0_wb_err_o, m0_wb_rty_o, m0_wb_stall_o;
    logic [31:0] m0_wb_dat_o;
    logic        m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i;
    logic [3:0]  m1_wb_adr_i, m1_wb_sel_i;
    logic [31:0] m1_wb_dat_i;
    logic        m1_wb_ack_o, m1_wb_err_o, m1_wb_rty_o, m1_wb_stall_o;
    logic [31:0] m1_wb_dat_o;
    logic        s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
    logic [3:0]  s_wb_adr_o, s_wb_sel_o;
    logic [31:0] s_wb_dat_o;
    logic        s_wb_ack_i, s_wb_err_i, s_wb_rty_i, s_wb_stall_i;
    logic [31:0] s_wb_dat_i;

    int errs   = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    wb_arb2_rr #(.ADDR_W(4), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_stb_i(m0_wb_stb_i), .m0_wb_we_i(m0_wb_we_i),
        .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_sel_i(m0_wb_sel_i), .m0_wb_dat_i(m0_wb_dat_i),
        .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_err_o(m0_wb_err_o), .m0_wb_rty_o(m0_wb_rty_o),
        .m0_wb_stall_o(m0_wb_stall_o), .m0_wb_dat_o(m0_wb_dat_o),
        .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_stb_i(m1_wb_stb_i), .m1_wb_we_i(m1_wb_we_i),
        .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_sel_i(m1_wb_sel_i), .m1_wb_dat_i(m1_wb_dat_i),
        .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_err_o(m1_wb_err_o), .m1_wb_rty_o(m1_wb_rty_o),
        .m1_wb_stall_o(m1_wb_stall_o), .m1_wb_dat_o(m1_wb_dat_o),
        .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_we_o(s_wb_we_o),
        .s_wb_adr_o(s_wb_adr_o), .s_wb_sel_o(s_wb_sel_o), .s_wb_dat_o(s_wb_dat_o),
        .s_wb_ack_i(s_wb_ack_i), .s_wb_err_i(s_wb_err_i), .s_wb_rty_i(s_wb_rty_i),
        .s_wb_stall_i(s_wb_stall_i), .s_wb_dat_i(s_wb_dat_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        m0_wb_cyc_i = 0; m0_wb_stb_i = 0; m0_wb_we_i = 0; m0_wb_adr_i = 0; m0_wb_sel_i = 0; m0_wb_dat_i = 0;
        m1_wb_cyc_i = 0; m1_wb_stb_i = 0; m1_wb_we_i = 0; m1_wb_adr_i = 0; m1_wb_sel_i = 0; m1_wb_dat_i = 0;
        s_wb_ack_i = 0; s_wb_err_i = 0; s_wb_rty_i = 0; s_wb_stall_i = 0; s_wb_dat_i = 0;
    endtask

    task automatic test_reset();
        rst_n_i = 0;
        m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m1_wb_cyc_i = 1; m1_wb_stb_i = 1;
        tick(); tick(); #1;
        checks++; if (s_wb_cyc_o !== 1'b0) begin errs++; $display("FAIL rst_s_cyc: got %b want 0", s_wb_cyc_o); end
        checks++; if (s_wb_stb_o !== 1'b0) begin errs++; $display("FAIL rst_s_stb: got %b want 0", s_wb_stb_o); end
        checks++; if (m0_wb_stall_o !== 1'b1) begin errs++; $display("FAIL rst_m0_stall: got %b want 1", m0_wb_stall_o); end
        checks++; if (m1_wb_stall_o !== 1'b1) begin errs++; $display("FAIL rst_m1_stall: got %b want 1", m1_wb_stall_o); end
        checks++; if ({m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_rty_o} !== 4'b0) begin errs++; $display("FAIL rst_resp: got %b want 0000", {m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_rty_o}); end
        idle_all();
        rst_n_i = 1;
        tick();
    endtask

    task automatic test_single_write();
        m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_we_i = 1; m0_wb_adr_i = 4'h4; m0_wb_sel_i = 4'hF; m0_wb_dat_i = 32'h1F;
        #1;
        checks++; if (m0_wb_stall_o !== 1'b0) begin errs++; $display("FAIL wr_accept_stall: got %b want 0", m0_wb_stall_o); end
        checks++; if (s_wb_stb_o !== 1'b0) begin errs++; $display("FAIL wr_c0_stb: got %b want 0", s_wb_stb_o); end
        tick();
        m0_wb_stb_i = 0; #1;
        checks++; if ({s_wb_cyc_o, s_wb_stb_o, s_wb_we_o} !== 3'b111) begin errs++; $display("FAIL wr_c1_ctl: got %b want 111", {s_wb_cyc_o, s_wb_stb_o, s_wb_we_o}); end
        checks++; if ({s_wb_adr_o, s_wb_sel_o, s_wb_dat_o} !== {4'h4, 4'hF, 32'h1F}) begin errs++; $display("FAIL wr_c1_fields: got %h want 4f0000001f", {s_wb_adr_o, s_wb_sel_o, s_wb_dat_o}); end
        checks++; if (m0_wb_stall_o !== 1'b1) begin errs++; $display("FAIL wr_c1_stall: got %b want 1", m0_wb_stall_o); end
        tick();
        s_wb_ack_i = 1; #1;
        checks++; if ({s_wb_cyc_o, s_wb_stb_o} !== 2'b10) begin errs++; $display("FAIL wr_c2_ctl: got %b want 10", {s_wb_cyc_o, s_wb_stb_o}); end
        checks++; if (m0_wb_ack_o !== 1'b0) begin errs++; $display("FAIL wr_c2_ack: got %b want 0", m0_wb_ack_o); end
        tick();
        s_wb_ack_i = 0; #1;
        checks++; if ({m0_wb_ack_o, m0_wb_err_o, m0_wb_rty_o} !== 3'b100) begin errs++; $display("FAIL wr_c3_resp: got %b want 100", {m0_wb_ack_o, m0_wb_err_o, m0_wb_rty_o}); end
        checks++; if (m0_wb_dat_o !== 32'h0) begin errs++; $display("FAIL wr_c3_dat: got %h want 0", m0_wb_dat_o); end
        checks++; if ({m1_wb_ack_o, m1_wb_err_o, m1_wb_rty_o, m1_wb_dat_o} !== 35'h0) begin errs++; $display("FAIL wr_c3_m1: got %h want 0", {m1_wb_ack_o, m1_wb_err_o, m1_wb_rty_o, m1_wb_dat_o}); end
        checks++; if (s_wb_cyc_o !== 1'b0) begin errs++; $display("FAIL wr_c3_cyc: got %b want 0", s_wb_cyc_o); end
        idle_all();
        tick(); #1;
        checks++; if (m0_wb_ack_o !== 1'b0) begin errs++; $display("FAIL wr_c4_ack: got %b want 0", m0_wb_ack_o); end
    endtask

    task automatic test_round_robin();
        logic g;
        rst_n_i = 0; tick(); rst_n_i = 1; tick();
        m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_adr_i = 4'hC; m0_wb_sel_i = 4'hF;
        m1_wb_cyc_i = 1; m1_wb_stb_i = 1; m1_wb_adr_i = 4'h8; m1_wb_sel_i = 4'hF;
        for (int k = 0; k < 4; k++) begin
            g = k[0];
            #1;
            checks++; if ((g ? m1_wb_stall_o : m0_wb_stall_o) !== 1'b0) begin errs++; $display("FAIL rr%0d_win_stall: got 1 want 0", k); end
            checks++; if ((g ? m0_wb_stall_o : m1_wb_stall_o) !== 1'b1) begin errs++; $display("FAIL rr%0d_lose_stall: got 0 want 1", k); end
            tick();
            if (g) m1_wb_stb_i = 0; else m0_wb_stb_i = 0;
            #1;
            checks++; if (s_wb_adr_o !== (g ? 4'h8 : 4'hC)) begin errs++; $display("FAIL rr%0d_adr: got %h want %h", k, s_wb_adr_o, g ? 4'h8 : 4'hC); end
            checks++; if ({s_wb_stb_o, m0_wb_stall_o, m1_wb_stall_o} !== 3'b111) begin errs++; $display("FAIL rr%0d_req: got %b want 111", k, {s_wb_stb_o, m0_wb_stall_o, m1_wb_stall_o}); end
            tick();
            s_wb_ack_i = 1; s_wb_dat_i = 32'hA0 + k;
            tick();
            s_wb_ack_i = 0; s_wb_dat_i = 0;
            if (g) m1_wb_stb_i = 1; else m0_wb_stb_i = 1;
            #1;
            checks++; if ({m0_wb_ack_o, m1_wb_ack_o} !== (g ? 2'b01 : 2'b10)) begin errs++; $display("FAIL rr%0d_ack: got %b want %b", k, {m0_wb_ack_o, m1_wb_ack_o}, g ? 2'b01 : 2'b10); end
            checks++; if ((g ? m1_wb_dat_o : m0_wb_dat_o) !== 32'hA0 + k) begin errs++; $display("FAIL rr%0d_dat: got %h want %h", k, g ? m1_wb_dat_o : m0_wb_dat_o, 32'hA0 + k); end
            if (k == 3) idle_all();
            tick();
        end
    endtask

    task automatic test_stall_read();
        m1_wb_cyc_i = 1; m1_wb_stb_i = 1; m1_wb_we_i = 0; m1_wb_adr_i = 4'h8; m1_wb_sel_i = 4'hF;
        #1;
        checks++; if (m1_wb_stall_o !== 1'b0) begin errs++; $display("FAIL sr_accept_stall: got %b want 0", m1_wb_stall_o); end
        tick();
        m1_wb_stb_i = 0; s_wb_stall_i = 1;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) s_wb_stall_i = 0;
            #1;
            checks++; if (s_wb_stb_o !== 1'b1) begin errs++; $display("FAIL sr_c%0d_stb: got %b want 1", c, s_wb_stb_o); end
            tick();
        end
        s_wb_ack_i = 1; s_wb_dat_i = 32'h5; #1;
        checks++; if ({s_wb_stb_o, m1_wb_ack_o} !== 2'b00) begin errs++; $display("FAIL sr_c4: got %b want 00", {s_wb_stb_o, m1_wb_ack_o}); end
        tick();
        s_wb_ack_i = 0; s_wb_dat_i = 0; #1;
        checks++; if (m1_wb_ack_o !== 1'b1) begin errs++; $display("FAIL sr_c5_ack: got %b want 1", m1_wb_ack_o); end
        checks++; if (m1_wb_dat_o !== 32'h5) begin errs++; $display("FAIL sr_c5_dat: got %h want 00000005", m1_wb_dat_o); end
        checks++; if (m0_wb_ack_o !== 1'b0) begin errs++; $display("FAIL sr_c5_m0: got %b want 0", m0_wb_ack_o); end
        idle_all();
        tick(); #1;
        checks++; if ({m1_wb_ack_o, m1_wb_dat_o} !== 33'h0) begin errs++; $display("FAIL sr_c6: got %h want 0", {m1_wb_ack_o, m1_wb_dat_o}); end
    endtask

    task automatic test_timeout();
        m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_we_i = 1; m0_wb_adr_i = 4'h0; m0_wb_sel_i = 4'h3; m0_wb_dat_i = 32'h99;
        #1;
        checks++; if (m0_wb_stall_o !== 1'b0) begin errs++; $display("FAIL to_accept_stall: got %b want 0", m0_wb_stall_o); end
        tick();
        m0_wb_stb_i = 0;
        tick();
        for (int c = 2; c <= 6; c++) begin
            #1;
            checks++; if ({s_wb_cyc_o, m0_wb_err_o} !== 2'b10) begin errs++; $display("FAIL to_c%0d_wait: got %b want 10", c, {s_wb_cyc_o, m0_wb_err_o}); end
            tick();
        end
        #1;
        checks++; if ({m0_wb_ack_o, m0_wb_err_o, m0_wb_rty_o} !== 3'b010) begin errs++; $display("FAIL to_c7_resp: got %b want 010", {m0_wb_ack_o, m0_wb_err_o, m0_wb_rty_o}); end
        checks++; if (s_wb_cyc_o !== 1'b0) begin errs++; $display("FAIL to_c7_cyc: got %b want 0", s_wb_cyc_o); end
        idle_all();
        tick(); #1;
        checks++; if ({s_wb_cyc_o, m0_wb_err_o} !== 2'b00) begin errs++; $display("FAIL to_c8: got %b want 00", {s_wb_cyc_o, m0_wb_err_o}); end
        m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_we_i = 0; m0_wb_adr_i = 4'h4;
        tick();
        m0_wb_stb_i = 0;
        tick();
        s_wb_ack_i = 1; s_wb_dat_i = 32'h33;
        tick();
        s_wb_ack_i = 0; s_wb_dat_i = 0; #1;
        checks++; if ({m0_wb_ack_o, m0_wb_err_o} !== 2'b10) begin errs++; $display("FAIL to_next_resp: got %b want 10", {m0_wb_ack_o, m0_wb_err_o}); end
        checks++; if (m0_wb_dat_o !== 32'h33) begin errs++; $display("FAIL to_next_dat: got %h want 00000033", m0_wb_dat_o); end
        idle_all();
        tick();
    endtask

    task automatic test_abort();
        m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_we_i = 1; m0_wb_adr_i = 4'hC;
        #1;
        checks++; if (m0_wb_stall_o !== 1'b0) begin errs++; $display("FAIL ab_accept_stall: got %b want 0", m0_wb_stall_o); end
        tick();
        m0_wb_stb_i = 0; m1_wb_cyc_i = 1; m1_wb_stb_i = 1; m1_wb_we_i = 0; m1_wb_adr_i = 4'h8;
        #1;
        checks++; if (m1_wb_stall_o !== 1'b1) begin errs++; $display("FAIL ab_c1_m1_stall: got %b want 1", m1_wb_stall_o); end
        tick();
        m0_wb_cyc_i = 0; #1;
        checks++; if (s_wb_cyc_o !== 1'b1) begin errs++; $display("FAIL ab_c2_cyc: got %b want 1", s_wb_cyc_o); end
        tick();
        s_wb_ack_i = 1; #1;
        checks++; if (s_wb_cyc_o !== 1'b0) begin errs++; $display("FAIL ab_c3_cyc: got %b want 0", s_wb_cyc_o); end
        checks++; if ({m0_wb_ack_o, m0_wb_err_o} !== 2'b00) begin errs++; $display("FAIL ab_c3_m0: got %b want 00", {m0_wb_ack_o, m0_wb_err_o}); end
        checks++; if (m1_wb_stall_o !== 1'b0) begin errs++; $display("FAIL ab_c3_m1_grant: got %b want 0", m1_wb_stall_o); end
        tick();
        s_wb_ack_i = 0; m1_wb_stb_i = 0; #1;
        checks++; if ({s_wb_stb_o, s_wb_adr_o} !== {1'b1, 4'h8}) begin errs++; $display("FAIL ab_c4_req: got %h want 18", {s_wb_stb_o, s_wb_adr_o}); end
        checks++; if ({m0_wb_ack_o, m1_wb_ack_o} !== 2'b00) begin errs++; $display("FAIL ab_c4_late: got %b want 00", {m0_wb_ack_o, m1_wb_ack_o}); end
        tick();
        s_wb_ack_i = 1; s_wb_dat_i = 32'h77;
        tick();
        s_wb_ack_i = 0; s_wb_dat_i = 0; #1;
        checks++; if ({m0_wb_ack_o, m1_wb_ack_o, m1_wb_dat_o} !== {2'b01, 32'h77}) begin errs++; $display("FAIL ab_c6_m1: got %h want 100000077", {m0_wb_ack_o, m1_wb_ack_o, m1_wb_dat_o}); end
        idle_all();
        tick();
    endtask

    task automatic test_reset_mid();
        m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_we_i = 1; m0_wb_adr_i = 4'h4;
        tick();
        m0_wb_stb_i = 0;
        tick();
        m1_wb_cyc_i = 1; m1_wb_stb_i = 1; m1_wb_adr_i = 4'h8;
        rst_n_i = 0; #1;
        checks++; if ({s_wb_cyc_o, s_wb_stb_o} !== 2'b00) begin errs++; $display("FAIL rm_s_ctl: got %b want 00", {s_wb_cyc_o, s_wb_stb_o}); end
        checks++; if ({m0_wb_stall_o, m1_wb_stall_o} !== 2'b11) begin errs++; $display("FAIL rm_stall: got %b want 11", {m0_wb_stall_o, m1_wb_stall_o}); end
        tick();
        m0_wb_stb_i = 1; s_wb_ack_i = 1; #1;
        checks++; if ({m0_wb_ack_o, m0_wb_err_o, m0_wb_stall_o} !== 3'b001) begin errs++; $display("FAIL rm_held: got %b want 001", {m0_wb_ack_o, m0_wb_err_o, m0_wb_stall_o}); end
        s_wb_ack_i = 0; rst_n_i = 1; #1;
        checks++; if ({m0_wb_stall_o, m1_wb_stall_o} !== 2'b01) begin errs++; $display("FAIL rm_m0_wins: got %b want 01", {m0_wb_stall_o, m1_wb_stall_o}); end
        tick();
        m0_wb_stb_i = 0; #1;
        checks++; if ({s_wb_stb_o, s_wb_adr_o} !== {1'b1, 4'h4}) begin errs++; $display("FAIL rm_req: got %h want 14", {s_wb_stb_o, s_wb_adr_o}); end
        tick();
        s_wb_ack_i = 1;
        tick();
        s_wb_ack_i = 0; #1;
        checks++; if ({m0_wb_ack_o, m1_wb_ack_o} !== 2'b10) begin errs++; $display("FAIL rm_resp: got %b want 10", {m0_wb_ack_o, m1_wb_ack_o}); end
        idle_all();
        tick();
    endtask

    initial begin
        idle_all();
        rst_n_i = 0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_stall_read();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
